// File: rtl/sa_cache_pkg.sv
// Shared cache/memory-side definitions: address geometry, word width and the
// responder FSM state type.
package sa_cache_pkg;

   localparam int TAG_W       = 18;
   localparam int INDEX_W     = 8;
   localparam int OFFSET_W    = 6;
   localparam int WORD_W      = 32;
   localparam int LINE_ADDR_W = 26;
   localparam int STAT_W      = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } mem_state_t;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sa_mem_line_ram.sv
// Line storage: 2^DEPTH_W words with one synchronous write port, one
// asynchronous read port and a per-line valid bit (only the valid bits reset).
module sa_mem_line_ram
   import sa_cache_pkg::*;
#(
   parameter int DEPTH_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_we,
   input  logic [DEPTH_W-1:0] i_waddr,
   input  logic [WORD_W-1:0]  i_wdata,
   input  logic [DEPTH_W-1:0] i_raddr,
   output logic [WORD_W-1:0]  o_rdata,
   output logic               o_rvalid
);

   localparam int LINES = 1 << DEPTH_W;

   logic [WORD_W-1:0] r_mem [0:LINES-1];
   logic [LINES-1:0]  r_valid;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_waddr] <= 1'b1;
      end
   end

   assign o_rdata  = r_mem[i_raddr];
   assign o_rvalid = r_valid[i_raddr];

endmodule

// File: rtl/sa_mem_responder.sv
// Fixed-latency memory responder for the cache miss/writeback path: accepts one
// line read or write, answers LATENCY cycles later, and keeps read/write stats.
module sa_mem_responder
   import sa_cache_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int DEPTH_W = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_mem_req,
   input  logic                   i_mem_rw,
   input  logic [LINE_ADDR_W-1:0] i_mem_addr,
   input  logic [WORD_W-1:0]      i_mem_wdata,
   output logic                   o_mem_ready,
   output logic                   o_memory_response,
   output logic [WORD_W-1:0]      o_memory_line,
   output logic [STAT_W-1:0]      o_rd_count,
   output logic [STAT_W-1:0]      o_wr_count
);

   localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

   mem_state_t          r_state;
   mem_state_t          w_state_next;
   logic                r_rw;
   logic [DEPTH_W-1:0]  r_idx;
   logic [WORD_W-1:0]   r_wdata;
   logic [3:0]          r_cnt;
   logic [STAT_W-1:0]   r_rd_cnt;
   logic [STAT_W-1:0]   r_wr_cnt;
   logic [STAT_W-1:0]   w_rd_cnt_next;
   logic [STAT_W-1:0]   w_wr_cnt_next;
   logic                w_accept;
   logic                w_we;
   logic [WORD_W-1:0]   w_ram_rdata;
   logic                w_ram_rvalid;

   // Tag bits above the storage index only alias; they are never stored.
   generate
      if (DEPTH_W < LINE_ADDR_W) begin : g_tag_unused
         logic w_unused_tag;
         assign w_unused_tag = ^i_mem_addr[LINE_ADDR_W-1:DEPTH_W];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (i_mem_req) begin
               w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         // Leave WAIT as the count steps down to zero, so RESP lands exactly
         // LATENCY cycles after the acceptance edge.
         S_WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_mem_ready       = (r_state == S_IDLE);
      o_memory_response = (r_state == S_RESP);
      w_accept          = (r_state == S_IDLE) && i_mem_req;
      w_we              = (r_state == S_RESP) && r_rw;
      o_memory_line     = '0;
      if ((r_state == S_RESP) && !r_rw && w_ram_rvalid) begin
         o_memory_line = w_ram_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= LOAD_CNT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rw    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_rw    <= i_mem_rw;
         r_idx   <= i_mem_addr[DEPTH_W-1:0];
         r_wdata <= i_mem_wdata;
      end
   end

   always_comb begin
      w_rd_cnt_next = r_rd_cnt;
      w_wr_cnt_next = r_wr_cnt;
      if (r_state == S_RESP) begin
         if (r_rw) begin
            w_wr_cnt_next = sat_inc(r_wr_cnt);
         end else begin
            w_rd_cnt_next = sat_inc(r_rd_cnt);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         r_rd_cnt <= w_rd_cnt_next;
         r_wr_cnt <= w_wr_cnt_next;
      end
   end

   assign o_rd_count = r_rd_cnt;
   assign o_wr_count = r_wr_cnt;

   sa_mem_line_ram #(
      .DEPTH_W (DEPTH_W)
   ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_we),
      .i_waddr  (r_idx),
      .i_wdata  (r_wdata),
      .i_raddr  (r_idx),
      .o_rdata  (w_ram_rdata),
      .o_rvalid (w_ram_rvalid)
   );

endmodule

// File: tb/tb_sa_mem_responder.sv
// Directed bench for sa_mem_responder: one LATENCY=4 and one LATENCY=1
// instance, selected by sel, sharing the request stimulus and reset.
module tb_sa_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, rw, sel;
   logic [25:0] addr;
   logic [31:0] wdata;

   logic        req4, rdy4, resp4;
   logic [31:0] line4;
   logic [15:0] rdc4, wrc4;
   logic        req1, rdy1, resp1;
   logic [31:0] line1;
   logic [15:0] rdc1, wrc1;

   logic        rdy, resp;
   logic [31:0] line;
   logic [15:0] rdc, wrc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign req4 = req & ~sel;
   assign req1 = req & sel;
   assign rdy  = sel ? rdy1  : rdy4;
   assign resp = sel ? resp1 : resp4;
   assign line = sel ? line1 : line4;
   assign rdc  = sel ? rdc1  : rdc4;
   assign wrc  = sel ? wrc1  : wrc4;

   sa_mem_responder #(.LATENCY(4), .DEPTH_W(10)) u_dut4 (
      .clk (clk), .rst (rst),
      .i_mem_req (req4), .i_mem_rw (rw), .i_mem_addr (addr), .i_mem_wdata (wdata),
      .o_mem_ready (rdy4), .o_memory_response (resp4), .o_memory_line (line4),
      .o_rd_count (rdc4), .o_wr_count (wrc4)
   );

   sa_mem_responder #(.LATENCY(1), .DEPTH_W(10)) u_dut1 (
      .clk (clk), .rst (rst),
      .i_mem_req (req1), .i_mem_rw (rw), .i_mem_addr (addr), .i_mem_wdata (wdata),
      .o_mem_ready (rdy1), .o_memory_response (resp1), .o_memory_line (line1),
      .o_rd_count (rdc1), .o_wr_count (wrc1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One transaction; lat = clock edges from acceptance to visible response.
   task automatic txn(input logic t_rw, input logic [25:0] t_addr, input logic [31:0] t_wd,
                      output int lat, output logic [31:0] t_line);
      int w = 0;
      while (!rdy && w < 50) begin
         @(negedge clk);
         w++;
      end
      rw = t_rw; addr = t_addr; wdata = t_wd; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      lat = 1;
      while (!resp && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      t_line = line;
      @(negedge clk);
   endtask

   task automatic do_read(input string tag, input logic [25:0] a, input logic [31:0] exp_line,
                          input int exp_lat);
      int          lat;
      logic [31:0] ln;
      txn(1'b0, a, 32'h0, lat, ln);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_line"}, ln, exp_line);
      chk({tag, "_idle_line"}, line, 32'h0);
   endtask

   task automatic do_write(input string tag, input logic [25:0] a, input logic [31:0] d,
                           input int exp_lat);
      int          lat;
      logic [31:0] ln;
      txn(1'b1, a, d, lat, ln);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_line"}, ln, 32'h0);
   endtask

   // Hold a read request continuously and measure spacing of three responses.
   task automatic held(input string tag, input int gap, input logic [31:0] exp_line);
      int          t[3];
      int          k   = 0;
      int          cyc = 0;
      logic [31:0] first_line = 32'h0;
      rw = 1'b0; addr = 26'h0000012; wdata = 32'h0; req = 1'b1;
      while (k < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (resp) begin
            if (k == 0) first_line = line;
            t[k] = cyc;
            k++;
         end
      end
      req = 1'b0;
      chk({tag, "_count"}, k, 3);
      chk({tag, "_line"}, first_line, exp_line);
      if (k == 3) begin
         chk({tag, "_gap1"}, t[1] - t[0], gap);
         chk({tag, "_gap2"}, t[2] - t[1], gap);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nresp;
      rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", rdy4, 1);
      chk("rst_resp", resp4, 0);
      chk("rst_line", line4, 0);
      chk("rst_rdc", rdc4, 0);
      chk("rst_wrc", wrc4, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready4", rdy4, 1);
      chk("post_rst_ready1", rdy1, 1);
      @(negedge clk);

      do_read("rd_abc", 26'h0000ABC, 32'h0, 4);
      chk("rd_abc_rdc", rdc, 1);
      chk("rd_abc_wrc", wrc, 0);

      do_write("wr_12", 26'h0000012, 32'hDEADBEEF, 4);
      chk("wr_12_wrc", wrc, 1);
      do_read("rd_12", 26'h0000012, 32'hDEADBEEF, 4);
      chk("rd_12_rdc", rdc, 2);

      do_write("wr_alias", 26'h0400012, 32'h00001234, 4);
      do_read("rd_alias", 26'h0000012, 32'h00001234, 4);
      do_read("rd_212", 26'h0000212, 32'h0, 4);
      chk("alias_wrc", wrc, 2);
      chk("alias_rdc", rdc, 4);

      // Accept a read, then pulse a write request while in WAIT.
      rw = 1'b0; addr = 26'h0000012; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rw = 1'b1; addr = 26'h0000077; wdata = 32'h5; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      nresp = 0;
      repeat (15) begin
         @(negedge clk);
         if (resp) nresp++;
      end
      chk("pulse_resp_count", nresp, 1);
      chk("pulse_wrc", wrc, 2);
      chk("pulse_rdc", rdc, 5);

      held("held4", 5, 32'h00001234);
      chk("held4_rdc", rdc, 8);
      chk("held4_ready", rdy, 1);

      // Reset two cycles after accepting a write.
      rw = 1'b1; addr = 26'h0000055; wdata = 32'hAAAA5555; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_resp", resp4, 0);
      chk("abort_rdc", rdc4, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready", rdy4, 1);
      chk("abort_wrc", wrc4, 0);
      nresp = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp4) nresp++;
      end
      chk("abort_no_resp", nresp, 0);
      do_read("rd_55", 26'h0000055, 32'h0, 4);
      do_read("rd_12_post", 26'h0000012, 32'h0, 4);
      chk("post_abort_wrc", wrc, 0);
      chk("post_abort_rdc", rdc, 2);

      force u_dut4.r_rd_cnt = 16'hFFFE;
      @(negedge clk);
      release u_dut4.r_rd_cnt;
      #1;
      chk("sat4_preload", rdc4, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         do_read("sat4_rd", 26'h0000012, 32'h0, 4);
         chk("sat4_rdc", rdc4, 16'hFFFF);
      end

      sel = 1'b1;
      @(negedge clk);
      do_read("l1_rd", 26'h0000030, 32'h0, 1);
      do_write("l1_wr", 26'h0000030, 32'hCAFEF00D, 1);
      do_read("l1_rd2", 26'h0000030, 32'hCAFEF00D, 1);
      chk("l1_rdc", rdc, 2);
      chk("l1_wrc", wrc, 1);
      held("held1", 2, 32'h0);
      chk("held1_rdc", rdc, 5);

      force u_dut1.r_rd_cnt = 16'hFFFE;
      @(negedge clk);
      release u_dut1.r_rd_cnt;
      #1;
      chk("sat1_preload", rdc1, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         do_read("sat1_rd", 26'h0000030, 32'hCAFEF00D, 1);
         chk("sat1_rdc", rdc1, 16'hFFFF);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sa_mem_responder.md
SA_MEM_RESPONDER -- requirements
Module: sa_mem_responder

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst, which is asynchronous and active-high.
REQ-002 Parameter LATENCY, default 4: cycles from request acceptance to response, legal range 1..15.
REQ-003 Parameter DEPTH_W, default 10: number of line-address LSBs used to index storage, giving 2^DEPTH_W lines.
REQ-004 clk  in  1  block clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 i_mem_req  in  1  request valid from the cache miss/writeback path.
REQ-007 i_mem_rw  in  1  1 = write line, 0 = read line.
REQ-008 i_mem_addr  in  26  line address, {tag[17:0], index[7:0]}.
REQ-009 i_mem_wdata  in  32  write line data.
REQ-010 o_mem_ready  out  1  high when a request can be accepted.
REQ-011 o_memory_response  out  1  one-cycle completion pulse for a read or write.
REQ-012 o_memory_line  out  32  read data, valid only while o_memory_response=1 for a read.
REQ-013 o_rd_count, o_wr_count  out  16 each  saturating counts of completed reads and writes.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-015 In IDLE, o_mem_ready SHALL be 1. When i_mem_req=1, the block SHALL capture rw, addr and wdata, load the counter with LATENCY-1, and go to WAIT.
REQ-016 In WAIT, o_mem_ready SHALL be 0. The counter SHALL decrement each cycle, and the FSM SHALL go to RESP when the counter is 0, so that the response asserts exactly LATENCY cycles after the acceptance edge.
REQ-017 In RESP, o_memory_response SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE; with LATENCY=1 it SHALL go directly from IDLE to RESP.
REQ-018 A write SHALL update storage[addr[DEPTH_W-1:0]] with the captured data and set that line's valid bit on the RESP cycle.
REQ-019 A read SHALL drive o_memory_line from the captured address: the stored data if the line's valid bit is set, otherwise 32'h0.
REQ-020 o_memory_line SHALL be 32'h0 whenever o_memory_response=0.
REQ-021 Requests while o_mem_ready=0 SHALL be ignored, with no queueing; the requester holds i_mem_req until it observes o_mem_ready=1 at a clock edge.
REQ-022 A read following a write to the same line SHALL return the written data.
REQ-023 Line addresses differing only above bit DEPTH_W-1 SHALL alias to the same storage line.
REQ-024 i_mem_req held high across RESP SHALL start a new transaction on the next IDLE cycle, giving a back-to-back throughput of one transaction per LATENCY+1 cycles.
REQ-025 o_rd_count and o_wr_count SHALL increment on the RESP cycle and saturate at 16'hFFFF.

Reset
REQ-026 On rst=1, asynchronously: FSM to IDLE, counter to 0, o_memory_response=0, o_memory_line=0, both counts 0, all valid bits 0.
REQ-027 Storage data SHALL NOT be reset; the valid bits alone make unwritten and post-reset lines read 0.
REQ-028 Reset during WAIT or RESP SHALL abort the transaction: no response, no storage update, no count change.
REQ-029 o_mem_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 The shared package sa_cache_pkg SHALL hold TAG_W=18, INDEX_W=8, OFFSET_W=6, WORD_W=32, LINE_ADDR_W=26, and the FSM state enum.
REQ-031 Storage SHALL be a single sub-module, sa_mem_line_ram, with one synchronous write port and one asynchronous read port, holding 2^DEPTH_W x 32 data plus the valid-bit vector.
REQ-032 The FSM, the latency counter and the statistics counters SHALL reside in sa_mem_responder.

Verification
REQ-033 Reset then read addr 26'h0000ABC -> response 4 cycles after acceptance, line=0, rd_count=1.
REQ-034 Write 32'hDEADBEEF to 26'h0000012, then read the same address -> read returns 32'hDEADBEEF, wr_count=1, rd_count=1.
REQ-035 Write 32'h1234 to addr 26'h0400012 (aliases to index 0x012 with DEPTH_W=10), then read 26'h0000012 -> returns 32'h1234.
REQ-036 Pulse a second i_mem_req during WAIT -> ignored, exactly one response; req held continuously -> responses every 5 cycles.
REQ-037 Assert rst two cycles after accepting a write -> no response, ready=1 after release, later read of that address returns 0.
REQ-038 Force rd_count to 16'hFFFE, then perform 3 reads -> count stays 16'hFFFF; repeat with LATENCY=1 -> response on the cycle after acceptance.
